// File: rtl/load_store_unit.sv
// Load/store initiator between execute and data memory; one request in flight, byte-addressed little-endian.
// Latency from handshake: error 1 cycle, load/sb/sw 2 cycles, sh 3 cycles (two byte writes).
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
module load_store_unit #(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_sb,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_SB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [2:0] {IDLE, LOAD, STORE, STORE_HI, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_error;

  logic [2:0]  w_size;
  logic        w_misalign;
  logic        w_is_store;
  logic [32:0] w_end;
  logic        w_err;
  logic        w_hs;
  logic        w_wr;
  logic        w_sb;
  logic [31:0] w_load_data;

  // Decode the incoming request: access size, alignment and direction.
  always_comb begin
    w_size     = 3'd4;
    w_misalign = 1'b1;
    w_is_store = 1'b0;
    case (req_op)
      OP_LB, OP_LBU: begin w_size = 3'd1; w_misalign = 1'b0; end
      OP_SB:         begin w_size = 3'd1; w_misalign = 1'b0; w_is_store = 1'b1; end
      OP_LH, OP_LHU: begin w_size = 3'd2; w_misalign = req_addr[0]; end
      OP_SH:         begin w_size = 3'd2; w_misalign = req_addr[0]; w_is_store = 1'b1; end
      OP_LW:         begin w_size = 3'd4; w_misalign = |req_addr[1:0]; end
      OP_SW:         begin w_size = 3'd4; w_misalign = |req_addr[1:0]; w_is_store = 1'b1; end
      default:       begin w_size = 3'd4; w_misalign = 1'b1; end
    endcase
  end

  // End address is computed in 33 bits so addresses near 2^32 cannot wrap into range.
  assign w_end = {1'b0, req_addr} + {30'd0, w_size};
  assign w_err = w_misalign | (w_end > 33'(MEM_BYTES));
  assign w_hs  = req_valid && (r_state == IDLE);

  // Size and sign extension of the combinational memory read for loads.
  always_comb begin
    w_load_data = mem_rdata;
    case (r_op)
      OP_LB:   w_load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      OP_LBU:  w_load_data = {24'd0, mem_rdata[7:0]};
      OP_LH:   w_load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      OP_LHU:  w_load_data = {16'd0, mem_rdata[15:0]};
      default: w_load_data = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state memory/handshake outputs.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_wr       = 1'b0;
    w_sb       = 1'b0;
    mem_addr   = r_addr;
    mem_wdata  = r_wdata;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)           w_next = RESP;
          else if (w_is_store) w_next = STORE;
          else                 w_next = LOAD;
        end
      end
      LOAD: w_next = RESP;
      STORE: begin
        w_wr   = 1'b1;
        w_sb   = (r_op != OP_SW);
        w_next = (r_op == OP_SH) ? STORE_HI : RESP;
      end
      STORE_HI: begin
        // Upper half of a halfword store goes out as a second byte write.
        mem_addr  = r_addr + 32'd1;
        mem_wdata = {24'd0, r_wdata[15:8]};
        w_wr      = 1'b1;
        w_sb      = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reset suppresses any write that would otherwise commit on this edge.
  assign mem_write = w_wr & ~reset;
  assign mem_sb    = w_sb & ~reset;

  // Request latch and response data/error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      if (w_hs) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= 32'd0;
        r_error <= w_err;
      end
      if (r_state == LOAD) r_rdata <= w_load_data;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit with a byte-array data memory and a reference model.
// Latency: checks response timing per request class against expected cycle counts.
// Backpressure: exercises resp_ready stalls and ignored requests while busy.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_sb;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int sb_cnt = 0;

  logic [7:0] tb_mem  [0:8191];
  logic [7:0] ref_mem [0:8191];

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, SB = 3'd3;
  localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, SH = 3'd6, SW = 3'd7;

  load_store_unit #(.MEM_BYTES(8192)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_sb(mem_sb), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Data memory: combinational little-endian read, byte or word write on the clock edge.
  always_comb begin
    logic [12:0] a;
    a = mem_addr[12:0];
    mem_rdata = {tb_mem[a + 13'd3], tb_mem[a + 13'd2], tb_mem[a + 13'd1], tb_mem[a]};
  end

  always @(posedge clock) begin
    logic [12:0] a;
    a = mem_addr[12:0];
    if (mem_write) begin
      wr_cnt = wr_cnt + 1;
      if (mem_sb) begin
        sb_cnt = sb_cnt + 1;
        tb_mem[a] = mem_wdata[7:0];
      end else begin
        tb_mem[a]         = mem_wdata[7:0];
        tb_mem[a + 13'd1] = mem_wdata[15:8];
        tb_mem[a + 13'd2] = mem_wdata[23:16];
        tb_mem[a + 13'd3] = mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input logic [2:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic bit ref_err(input logic [2:0] op, input logic [31:0] addr);
    longint a;
    int sz;
    a  = longint'({32'd0, addr});
    sz = op_size(op);
    return ((a % sz) != 0) || (a + sz > 8192);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    longint v;
    int sz;
    logic [31:0] ai;
    logic [63:0] bits;
    v  = 0;
    sz = op_size(op);
    for (int i = 0; i < sz; i++) begin
      ai = addr + i;
      v  = v + (longint'(ref_mem[ai[12:0]]) << (8 * i));
    end
    if ((op == LB || op == LH) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    bits = v;
    return bits[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] ai;
    logic [31:0] sh;
    for (int i = 0; i < op_size(op); i++) begin
      ai = addr + i;
      sh = wd >> (8 * i);
      ref_mem[ai[12:0]] = sh[7:0];
    end
  endtask

  // Drives one request with resp_ready high and reports what was observed.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int wr, output int sbw, output logic idle_after);
    wr_cnt = 0;
    sb_cnt = 0;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_error;
    @(posedge clock); #1;
    idle_after = !resp_valid && req_ready;
    wr  = wr_cnt;
    sbw = sb_cnt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b exp=0", mem_write); end
    reset = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", resp_error); end
    total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    total++; if (mem_sb !== 1'b0) begin bad++; $display("FAIL rst_mem_sb got=%b exp=0", mem_sb); end
  endtask

  task automatic test_word();
    int lat, wr, sbw; logic [31:0] rd; logic er, idl;
    do_req(SW, 32'h10, 32'hA1B2C3D4, lat, rd, er, wr, sbw, idl);
    ref_store(SW, 32'h10, 32'hA1B2C3D4);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    total++; if (wr !== 1 || sbw !== 0) begin bad++; $display("FAIL sw_writes got=%0d/%0d exp=1/0", wr, sbw); end
    total++; if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL sw_resp got=%b/%h exp=0/0", er, rd); end
    total++; if (idl !== 1'b1) begin bad++; $display("FAIL sw_idle got=%b exp=1", idl); end
    do_req(LW, 32'h10, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'hA1B2C3D4 || er !== 1'b0) begin bad++; $display("FAIL lw_data got=%h/%b exp=a1b2c3d4/0", rd, er); end
    total++; if (wr !== 0) begin bad++; $display("FAIL lw_nowrite got=%0d exp=0", wr); end
  endtask

  task automatic test_half();
    int lat, wr, sbw; logic [31:0] rd; logic er, idl;
    do_req(SH, 32'h22, 32'h0000BEEF, lat, rd, er, wr, sbw, idl);
    ref_store(SH, 32'h22, 32'h0000BEEF);
    total++; if (lat !== 3) begin bad++; $display("FAIL sh_latency got=%0d exp=3", lat); end
    total++; if (wr !== 2 || sbw !== 2) begin bad++; $display("FAIL sh_writes got=%0d/%0d exp=2/2", wr, sbw); end
    total++; if (tb_mem[13'h22] !== 8'hEF || tb_mem[13'h23] !== 8'hBE) begin bad++; $display("FAIL sh_bytes got=%h/%h exp=ef/be", tb_mem[13'h22], tb_mem[13'h23]); end
    do_req(LHU, 32'h22, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (rd !== 32'h0000BEEF || lat !== 2) begin bad++; $display("FAIL lhu_data got=%h lat=%0d exp=0000beef lat=2", rd, lat); end
    do_req(LH, 32'h22, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh_data got=%h exp=ffffbeef", rd); end
  endtask

  task automatic test_byte();
    int lat, wr, sbw; logic [31:0] rd; logic er, idl;
    do_req(SB, 32'h31, 32'h00000080, lat, rd, er, wr, sbw, idl);
    ref_store(SB, 32'h31, 32'h00000080);
    total++; if (lat !== 2 || wr !== 1 || sbw !== 1) begin bad++; $display("FAIL sb_write got lat=%0d wr=%0d sb=%0d exp 2/1/1", lat, wr, sbw); end
    do_req(LB, 32'h31, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", rd); end
    do_req(LBU, 32'h31, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", rd); end
    do_req(LW, 32'h30, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (rd !== 32'h00008000) begin bad++; $display("FAIL sb_word got=%h exp=00008000", rd); end
  endtask

  task automatic test_errors();
    logic [2:0]  ops   [7] = '{LW, SH, LW, LH, SB, LW, SW};
    logic [31:0] addrs [7] = '{32'h13, 32'h21, 32'h1FFE, 32'h1FFF, 32'h2000, 32'hFFFFFFFC, 32'h1FFD};
    int lat, wr, sbw; logic [31:0] rd; logic er, idl;
    for (int i = 0; i < 7; i++) begin
      do_req(ops[i], addrs[i], 32'hDEADBEEF, lat, rd, er, wr, sbw, idl);
      total++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || wr !== 0 || idl !== 1'b1) begin
        bad++;
        $display("FAIL err_case%0d got lat=%0d err=%b rd=%h wr=%0d idle=%b exp 1/1/0/0/1", i, lat, er, rd, wr, idl);
      end
    end
    do_req(LB, 32'h1FFF, 32'h0, lat, rd, er, wr, sbw, idl);
    total++; if (er !== 1'b0 || lat !== 2 || rd !== ref_load(LB, 32'h1FFF)) begin bad++; $display("FAIL top_byte got err=%b lat=%0d rd=%h exp 0/2/%h", er, lat, rd, ref_load(LB, 32'h1FFF)); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_rd;
    int n;
    exp_rd = ref_load(LW, 32'h10);
    wr_cnt = 0;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = LW; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_op = SW; req_addr = 32'h10; req_wdata = 32'h11223344;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_busy_ready got=%b exp=0", req_ready); end
    n = 0;
    while (!resp_valid && n < 8) begin @(posedge clock); #1; n++; end
    total++; if (n !== 1) begin bad++; $display("FAIL stall_latency got=%0d exp=1 extra cycle", n); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_error !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b rd=%h e=%b rdy=%b exp 1/%h/0/0", c, resp_valid, resp_rdata, resp_error, req_ready, exp_rd);
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL stall_release got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL stall_ignored got writes=%0d exp=0", wr_cnt); end
  endtask

  task automatic test_reset_mid_sh();
    logic [7:0] old41;
    int seen;
    old41 = ref_mem[13'h41];
    req_valid = 1'b1; req_op = SH; req_addr = 32'h40; req_wdata = 32'h00001234;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    total++; if (mem_write !== 1'b0 || mem_sb !== 1'b0) begin bad++; $display("FAIL rstmid_gate got w=%b sb=%b exp 0/0", mem_write, mem_sb); end
    @(posedge clock); #1;
    reset = 1'b0;
    ref_mem[13'h40] = 8'h34;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", req_ready); end
    total++; if (tb_mem[13'h40] !== 8'h34 || tb_mem[13'h41] !== old41) begin bad++; $display("FAIL rstmid_bytes got=%h/%h exp=34/%h", tb_mem[13'h40], tb_mem[13'h41], old41); end
    seen = 0;
    repeat (4) begin @(posedge clock); #1; if (resp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_noresp got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    int lat, wr, sbw, exp_lat, exp_wr, kind, sz;
    logic [31:0] rd, addr, wd, exp_rd;
    logic er, idl, exp_er;
    logic [2:0] op;
    for (int it = 0; it < 120; it++) begin
      op   = 3'($urandom_range(0, 7));
      sz   = op_size(op);
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = $urandom;
      else if (kind == 1) addr = 32'd8192 - 32'($urandom_range(0, 8));
      else                addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) addr = addr & ~(32'(sz) - 32'd1);
      wd = $urandom;
      exp_er  = ref_err(op, addr);
      exp_rd  = (exp_er || op_store(op)) ? 32'd0 : ref_load(op, addr);
      exp_lat = exp_er ? 1 : (op == SH ? 3 : 2);
      exp_wr  = (exp_er || !op_store(op)) ? 0 : (op == SH ? 2 : 1);
      do_req(op, addr, wd, lat, rd, er, wr, sbw, idl);
      if (!exp_er && op_store(op)) ref_store(op, addr, wd);
      total++;
      if (lat !== exp_lat || rd !== exp_rd || er !== exp_er || wr !== exp_wr ||
          sbw !== ((op == SW) ? 0 : exp_wr) || idl !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d op=%0d addr=%h got lat=%0d rd=%h e=%b wr=%0d sb=%0d idle=%b exp lat=%0d rd=%h e=%b wr=%0d",
                 it, op, addr, lat, rd, er, wr, sbw, idl, exp_lat, exp_rd, exp_er, exp_wr);
      end
    end
    for (int a = 0; a < 512; a++) begin
      if (tb_mem[a] !== ref_mem[a]) begin
        total++; bad++;
        $display("FAIL rand_mem addr=%0h got=%h exp=%h", a, tb_mem[a], ref_mem[a]);
      end
    end
    total++; if (tb_mem[13'h1FFC] !== ref_mem[13'h1FFC]) begin bad++; $display("FAIL rand_mem_top got=%h exp=%h", tb_mem[13'h1FFC], ref_mem[13'h1FFC]); end
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 8192; i++) begin
      v = (i >= 256) ? 8'($urandom) : 8'd0;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_word();
    test_half();
    test_byte();
    test_errors();
    test_stall();
    test_reset_mid_sh();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
